// File: rtl/ahb_icx_pkg.sv
// ---------------------------------------------------------------------------
// ahb_icx_pkg
// Shared definitions for the AHB-Lite single-master interconnect:
//   - data-phase owner state encoding
//   - HTRANS encodings
//   - slave count limit and slave index width
// ---------------------------------------------------------------------------
package ahb_icx_pkg;

  localparam int MAX_SLAVES = 16;
  localparam int IDX_W      = $clog2(MAX_SLAVES);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SLV  = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } icx_state_e;

  // True for transfers that must be answered by a real or default slave.
  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_icx_decoder.sv
// ---------------------------------------------------------------------------
// ahb_icx_decoder
// Combinational address decoder. A slave matches when
// (haddr & mask) == base; the lowest-index matching slave wins.
// Ports:
//   haddr_i   in   32         master address
//   hit_o     out  N_SLAVES   one-hot select of the winning slave (0 if none)
//   idx_o     out  IDX_W      index of the winning slave (0 if none)
//   nomap_o   out  1          no slave matched
// ---------------------------------------------------------------------------
module ahb_icx_decoder
  import ahb_icx_pkg::*;
#(
  parameter int                      N_SLAVES = 5,
  parameter logic [N_SLAVES*32-1:0]  SLV_BASE = '0,
  parameter logic [N_SLAVES*32-1:0]  SLV_MASK = '0
) (
  input  logic [31:0]          haddr_i,
  output logic [N_SLAVES-1:0]  hit_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 nomap_o
);

  logic [N_SLAVES-1:0] match;

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_match
    assign match[g] = (haddr_i & SLV_MASK[g*32 +: 32]) == SLV_BASE[g*32 +: 32];
  end

  // Walk from the top index down so the lowest matching index is the last
  // one written and therefore wins on overlap.
  always_comb begin
    hit_o = '0;
    idx_o = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_o    = '0;
        hit_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end

  assign nomap_o = ~|match;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// ---------------------------------------------------------------------------
// ahb_lite_interconnect
// Single-master AHB-Lite interconnect: programmable address decoder,
// data-phase response mux and a built-in default slave that answers
// unmapped NONSEQ/SEQ transfers with a two-cycle ERROR.
//
// Optional feature macro: ICX_TIMEOUT_EN
//   defined     - a slave stalling TIMEOUT_CYC consecutive cycles is aborted
//                 with a two-cycle ERROR; its later HREADYOUT is ignored.
//   not defined - no timeout, slaves may stall indefinitely.
//
// Ports:
//   HCLK         in   1                 bus clock
//   resetHW      in   1                 synchronous active-high reset
//   HADDR        in   32                master address
//   HTRANS       in   2                 master transfer type
//   HSEL_s       out  N_SLAVES          one-hot slave select (combinational)
//   HRDATA_s     in   N_SLAVES*DATA_W   flattened slave read data
//   HREADYOUT_s  in   N_SLAVES          slave ready outputs
//   HRESP_s      in   N_SLAVES          slave error responses
//   HRDATA       out  DATA_W            read data to master
//   HREADY       out  1                 ready to master and all slaves
//   HRESP        out  1                 response to master (1 = ERROR)
//   nomap        out  1                 pulse in first ERR1 cycle of an
//                                       unmapped NONSEQ/SEQ transfer
//
// State | meaning
// IDLE  | no data phase in progress, zero-wait OKAY
// SLV   | data phase owned by slave idx_q, its response is forwarded
// ERR1  | default slave / timeout, first ERROR cycle (HREADY=0)
// ERR2  | default slave / timeout, second ERROR cycle (HREADY=1)
// ---------------------------------------------------------------------------
module ahb_lite_interconnect
  import ahb_icx_pkg::*;
#(
  parameter int                      N_SLAVES    = 5,
  parameter int                      DATA_W      = 32,
  parameter logic [N_SLAVES*32-1:0]  SLV_BASE    = {32'h4002_0000, 32'h4001_0000,
                                                    32'h4000_0000, 32'h2000_0000,
                                                    32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0]  SLV_MASK    = {32'hFFFF_0000, 32'hFFFF_0000,
                                                    32'hFFFF_0000, 32'hFF00_0000,
                                                    32'hFF00_0000},
  parameter logic [DATA_W-1:0]       BAD_DATA    = DATA_W'(32'hdeadbeef),
  parameter int                      TIMEOUT_CYC = 256
) (
  input  logic                          HCLK,
  input  logic                          resetHW,
  input  logic [31:0]                   HADDR,
  input  logic [1:0]                    HTRANS,
  output logic [N_SLAVES-1:0]           HSEL_s,
  input  logic [N_SLAVES*DATA_W-1:0]    HRDATA_s,
  input  logic [N_SLAVES-1:0]           HREADYOUT_s,
  input  logic [N_SLAVES-1:0]           HRESP_s,
  output logic [DATA_W-1:0]             HRDATA,
  output logic                          HREADY,
  output logic                          HRESP,
  output logic                          nomap
);

  icx_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 nomap_q, nomap_d;

  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_nomap;

  logic [DATA_W-1:0]    slv_rdata;
  logic                 slv_ready;
  logic                 slv_resp;

  logic                 accept;
  logic                 hready_c;
  logic                 hresp_c;
  logic [DATA_W-1:0]    hrdata_c;

`ifdef ICX_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0]           tmo_q, tmo_d;
`endif

  ahb_icx_decoder #(
    .N_SLAVES (N_SLAVES),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decoder (
    .haddr_i  (HADDR),
    .hit_o    (HSEL_s),
    .idx_o    (dec_idx),
    .nomap_o  (dec_nomap)
  );

  // Response mux keyed by the registered data-phase owner, not the live
  // decode, since the address phase has already moved on.
  always_comb begin
    slv_rdata = '0;
    slv_ready = 1'b1;
    slv_resp  = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slv_rdata = HRDATA_s[i*DATA_W +: DATA_W];
        slv_ready = HREADYOUT_s[i];
        slv_resp  = HRESP_s[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nomap_d  = 1'b0;
    accept   = 1'b0;
    hready_c = 1'b1;
    hresp_c  = 1'b0;
    hrdata_c = '0;
`ifdef ICX_TIMEOUT_EN
    tmo_d    = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        accept = 1'b1;
      end
      ST_SLV: begin
        hready_c = slv_ready;
        hresp_c  = slv_resp;
        hrdata_c = slv_rdata;
        accept   = slv_ready;
`ifdef ICX_TIMEOUT_EN
        // Stall cycle TIMEOUT_CYC is the last one the slave gets; the
        // counter then restarts from zero for the next owner.
        if (!slv_ready) begin
          if (tmo_q == TMO_LAST) begin
            state_d = ST_ERR1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
`endif
      end
      ST_ERR1: begin
        hready_c = 1'b0;
        hresp_c  = 1'b1;
        hrdata_c = BAD_DATA;
        state_d  = ST_ERR2;
      end
      ST_ERR2: begin
        hready_c = 1'b1;
        hresp_c  = 1'b1;
        hrdata_c = BAD_DATA;
        accept   = 1'b1;
      end
    endcase

    // Acceptance in the final data-phase cycle overrides the owner with no
    // bubble. IDLE/BUSY to a mapped slave still hands it the data phase so
    // the slave supplies its own zero-wait OKAY.
    if (accept) begin
      if (!dec_nomap) begin
        state_d = ST_SLV;
        idx_d   = dec_idx;
      end else if (is_active_trans(HTRANS)) begin
        state_d = ST_ERR1;
        nomap_d = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (resetHW) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      nomap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nomap_q <= nomap_d;
    end
  end

`ifdef ICX_TIMEOUT_EN
  always_ff @(posedge HCLK) begin
    if (resetHW) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign HRDATA = hrdata_c;
  assign HREADY = hready_c;
  assign HRESP  = hresp_c;
  assign nomap  = nomap_q;

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
module tb_ahb_lite_interconnect;

  localparam int NS  = 5;
  localparam int TMO = 8;
`ifdef ICX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // Slave 0 ROM, 1 RAM, 2 at 0x50xx_xxxx, 3 GPIO, 4 overlaps slave 2.
  localparam logic [31:0] BASE_A [NS] = '{32'h0000_0000, 32'h2000_0000, 32'h5000_0000,
                                          32'h4000_0000, 32'h5000_0000};
  localparam logic [31:0] MASK_A [NS] = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000,
                                          32'hFFFF_0000, 32'hF000_0000};
  localparam logic [NS*32-1:0] P_BASE = {32'h5000_0000, 32'h4000_0000, 32'h5000_0000,
                                         32'h2000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] P_MASK = {32'hF000_0000, 32'hFFFF_0000, 32'hFF00_0000,
                                         32'hFF00_0000, 32'hFF00_0000};
  localparam logic [31:0] BAD = 32'hdeadbeef;
  localparam logic [31:0] A_UNMAP = 32'h9000_0000;
  localparam logic [31:0] A_RAM   = 32'h2000_0010;
  localparam logic [31:0] A_GPIO  = 32'h4000_0004;
  localparam logic [31:0] A_OVL   = 32'h5000_0000;

  logic               HCLK = 1'b0;
  logic               resetHW;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic [NS-1:0]      HSEL_s;
  logic [NS*32-1:0]   HRDATA_s;
  logic [NS-1:0]      HREADYOUT_s;
  logic [NS-1:0]      HRESP_s;
  logic [31:0]        HRDATA;
  logic               HREADY;
  logic               HRESP;
  logic               nomap;

  logic [31:0]        sdata [NS];

  always #5 HCLK = ~HCLK;

  always_comb begin
    HRDATA_s = '0;
    for (int i = 0; i < NS; i++) HRDATA_s[i*32 +: 32] = sdata[i];
  end

  ahb_lite_interconnect #(
    .N_SLAVES    (NS),
    .DATA_W      (32),
    .SLV_BASE    (P_BASE),
    .SLV_MASK    (P_MASK),
    .BAD_DATA    (BAD),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .HCLK        (HCLK),
    .resetHW     (resetHW),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL_s      (HSEL_s),
    .HRDATA_s    (HRDATA_s),
    .HREADYOUT_s (HREADYOUT_s),
    .HRESP_s     (HRESP_s),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .nomap       (nomap)
  );

  // Scoreboard entry: owner of a data phase. kind 0 = idle OKAY,
  // 1 = slave idx, 2 = two-cycle ERROR (tmo marks a timeout abort).
  typedef struct {
    int kind;
    int idx;
    bit tmo;
  } ent_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   err_cyc = 0;
  int   stall = 0;
  int   nm_seen = 0;

  function automatic int dec(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK_A[i]) == BASE_A[i]) return i;
    return -1;
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Compare one cycle's outputs at the falling edge, then retire/push
  // scoreboard entries according to what the model says was accepted.
  task automatic step();
    ent_t        f;
    ent_t        n;
    logic        e_rdy, e_resp, e_nm;
    logic [31:0] e_data;
    logic [NS-1:0] e_sel;
    int          d;
    @(negedge HCLK);
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      sb.push_back('{0, 0, 1'b0});
    end
    f = sb[0];
    if (TMO_EN && f.kind == 1 && stall == TMO) begin
      f.kind = 2; f.tmo = 1'b1; sb[0] = f; err_cyc = 0; stall = 0;
    end
    e_nm = 1'b0;
    case (f.kind)
      1: begin e_rdy = HREADYOUT_s[f.idx]; e_resp = HRESP_s[f.idx]; e_data = sdata[f.idx]; end
      2: begin e_rdy = (err_cyc != 0); e_resp = 1'b1; e_data = BAD; e_nm = (err_cyc == 0) && !f.tmo; end
      default: begin e_rdy = 1'b1; e_resp = 1'b0; e_data = '0; end
    endcase
    d = dec(HADDR);
    e_sel = '0;
    if (d >= 0) e_sel[d] = 1'b1;

    check1("hready", 32'(HREADY), 32'(e_rdy));
    check1("hresp",  32'(HRESP),  32'(e_resp));
    check1("hrdata", HRDATA, e_data);
    check1("hsel",   32'(HSEL_s), 32'(e_sel));
    check1("nomap",  32'(nomap),  32'(e_nm));
    if (nomap) nm_seen++;

    if (resetHW) begin
      sb.delete();
      sb.push_back('{0, 0, 1'b0});
      err_cyc = 0; stall = 0;
    end else if (e_rdy) begin
      void'(sb.pop_front());
      if (d >= 0)          n = '{1, d, 1'b0};
      else if (HTRANS[1])  n = '{2, 0, 1'b0};
      else                 n = '{0, 0, 1'b0};
      sb.push_back(n);
      err_cyc = 0; stall = 0;
    end else begin
      if (f.kind == 2) err_cyc++;
      if (f.kind == 1) stall++;
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t);
    HADDR = a;
    HTRANS = t;
  endtask

  initial begin
    sdata[0] = 32'h0B0B_0000;
    sdata[1] = 32'h1234_5678;
    sdata[2] = 32'h2222_2222;
    sdata[3] = 32'h3333_3333;
    sdata[4] = 32'h4444_4444;
    resetHW = 1'b1;
    HREADYOUT_s = '1;
    HRESP_s = '0;
    drive(A_UNMAP, 2'b00);
    repeat (3) @(posedge HCLK);
    #1;
    resetHW = 1'b0;
    sb.push_back('{0, 0, 1'b0});

    // Reset state
    check1("rst_hready", 32'(HREADY), 32'd1);
    check1("rst_hresp",  32'(HRESP),  32'd0);
    check1("rst_hrdata", HRDATA,      32'd0);
    check1("rst_nomap",  32'(nomap),  32'd0);
    step();

    // RAM NONSEQ read
    drive(A_RAM, 2'b10);
    #1 check1("ram_hsel", 32'(HSEL_s), 32'b00010);
    step();
    drive(A_UNMAP, 2'b00);
    check1("ram_data_next", HRDATA, 32'h1234_5678);
    step();

    // Unmapped NONSEQ: ERR1, ERR2, single nomap pulse
    nm_seen = 0;
    drive(A_UNMAP, 2'b10);
    step();
    drive(A_UNMAP, 2'b00);
    check1("err1_hready", 32'(HREADY), 32'd0);
    step();
    check1("err2_hready", 32'(HREADY), 32'd1);
    step();
    step();
    check1("nomap_pulses", 32'(nm_seen), 32'd1);

    // Unmapped IDLE: stays OKAY
    step();
    check1("idle_unmap_hresp", 32'(HRESP), 32'd0);

    // Back-to-back: RAM with two wait states then GPIO accepted in last cycle
    drive(A_RAM, 2'b10);
    step();
    HREADYOUT_s[1] = 1'b0;
    drive(A_UNMAP, 2'b00);
    step();
    step();
    HREADYOUT_s[1] = 1'b1;
    drive(A_GPIO, 2'b10);
    step();
    drive(A_UNMAP, 2'b00);
    check1("b2b_gpio_data", HRDATA, 32'h3333_3333);
    step();

    // Overlapping slaves 2 and 4: lowest index wins
    drive(A_OVL, 2'b10);
    #1 check1("overlap_hsel", 32'(HSEL_s), 32'b00100);
    step();
    drive(A_UNMAP, 2'b00);
    step();

    // Slave ERROR forwarded
    HRESP_s[3] = 1'b1;
    drive(A_GPIO, 2'b11);
    step();
    drive(A_UNMAP, 2'b00);
    step();
    HRESP_s[3] = 1'b0;

    // Unmapped SEQ also errors; BUSY does not
    drive(A_UNMAP, 2'b11);
    step();
    drive(A_UNMAP, 2'b01);
    step();
    step();
    step();

    // Reset during ERR1
    drive(A_UNMAP, 2'b10);
    step();
    drive(A_UNMAP, 2'b00);
    resetHW = 1'b1;
    step();
    resetHW = 1'b0;
    check1("post_rst_hready", 32'(HREADY), 32'd1);
    check1("post_rst_hresp",  32'(HRESP),  32'd0);
    step();

    // Long stall: ERROR after TMO stall cycles with timeout, otherwise held
    drive(A_RAM, 2'b10);
    step();
    HREADYOUT_s[1] = 1'b0;
    drive(A_UNMAP, 2'b00);
    repeat (TMO + 6) step();
    HREADYOUT_s[1] = 1'b1;
    repeat (2) step();

    // Mixed traffic
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: drive(A_RAM, 2'($urandom_range(0, 3)));
        1: drive(A_GPIO, 2'($urandom_range(0, 3)));
        2: drive(A_OVL, 2'($urandom_range(0, 3)));
        3: drive(32'h0000_0100, 2'($urandom_range(0, 3)));
        4: drive(32'h4800_0000, 2'($urandom_range(0, 3)));
        default: drive(A_UNMAP, 2'($urandom_range(0, 3)));
      endcase
      HREADYOUT_s = NS'($urandom_range(0, 31)) | NS'(5'b10101);
      HRESP_s = (k % 7 == 0) ? NS'(5'b00010) : '0;
      step();
    end
    HREADYOUT_s = '1;
    HRESP_s = '0;
    drive(A_UNMAP, 2'b00);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
